// File: rtl/egress_pkt_arbiter.sv
// Packet-granular round-robin arbiter draining two FWFT egress queues into one tx channel.
// Also keeps per-source packet counters and a saturating framing-error counter.
module egress_pkt_arbiter #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned KEEP_WIDTH  = 8,
  parameter int unsigned USER_WIDTH  = 16,
  parameter int unsigned QUEUE_WIDTH = 288
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_src0_empty,
  output logic                   o_src0_rd_en,
  input  logic [QUEUE_WIDTH-1:0] iv_src0_data,
  input  logic                   i_src1_empty,
  output logic                   o_src1_rd_en,
  input  logic [QUEUE_WIDTH-1:0] iv_src1_data,
  output logic                   o_tx_pkt_valid,
  output logic                   o_tx_pkt_start,
  output logic                   o_tx_pkt_end,
  output logic [USER_WIDTH-1:0]  ov_tx_pkt_user,
  output logic [KEEP_WIDTH-1:0]  ov_tx_pkt_keep,
  output logic [DATA_WIDTH-1:0]  ov_tx_pkt_data,
  input  logic                   i_tx_pkt_ready,
  output logic                   o_busy,
  output logic [31:0]            ov_src0_pkt_cnt,
  output logic [31:0]            ov_src1_pkt_cnt,
  output logic [15:0]            ov_err_cnt
);

  localparam int unsigned KEEP_LSB  = DATA_WIDTH;
  localparam int unsigned USER_LSB  = KEEP_LSB + KEEP_WIDTH;
  localparam int unsigned START_BIT = USER_LSB + USER_WIDTH;
  localparam int unsigned END_BIT   = START_BIT + 1;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned ERR_W     = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    first_beat_q, first_beat_d;
  logic                    valid_q, valid_d;
  logic                    start_q, start_d;
  logic                    end_q, end_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        src0_cnt_q, src0_cnt_d;
  logic [CNT_W-1:0]        src1_cnt_q, src1_cnt_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic                    busy_q, busy_d;

  logic                    pop_c;
  logic                    head_empty_c;
  logic [QUEUE_WIDTH-1:0]  head_c;

  // Reserved word bits carry no meaning here.
  logic unused_rsvd;
  assign unused_rsvd = ^{iv_src0_data[QUEUE_WIDTH-1:END_BIT+1], iv_src1_data[QUEUE_WIDTH-1:END_BIT+1]};

  assign head_c       = grant_q ? iv_src1_data : iv_src0_data;
  assign head_empty_c = grant_q ? i_src1_empty : i_src0_empty;

  // Arbitration, pop, framing and counter next-state logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_beat_d = first_beat_q;
    valid_d      = valid_q;
    start_d      = start_q;
    end_d        = end_q;
    user_d       = user_q;
    keep_d       = keep_q;
    data_d       = data_q;
    src0_cnt_d   = src0_cnt_q;
    src1_cnt_d   = src1_cnt_q;
    err_cnt_d    = err_cnt_q;
    pop_c        = 1'b0;

    if (valid_q && i_tx_pkt_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_enable && (!i_src0_empty || !i_src1_empty)) begin
          if (!i_src0_empty && !i_src1_empty) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = i_src0_empty;
          end
          first_beat_d = 1'b1;
          state_d      = ST_XFER;
        end
      end
      ST_XFER: begin
        pop_c = !head_empty_c && (!valid_q || i_tx_pkt_ready);
        if (pop_c) begin
          if (first_beat_q && !head_c[START_BIT]) begin
            // Orphan mid-packet word: drop it and keep hunting for a start.
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
          end else begin
            valid_d      = 1'b1;
            data_d       = head_c[DATA_WIDTH-1:0];
            keep_d       = head_c[KEEP_LSB +: KEEP_WIDTH];
            user_d       = head_c[USER_LSB +: USER_WIDTH];
            start_d      = head_c[START_BIT];
            end_d        = head_c[END_BIT];
            first_beat_d = 1'b0;
            if (head_c[END_BIT]) begin
              last_grant_d = grant_q;
              state_d      = ST_IDLE;
              if (grant_q) begin
                src1_cnt_d = src1_cnt_q + CNT_W'(1);
              end else begin
                src0_cnt_d = src0_cnt_q + CNT_W'(1);
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_beat_q <= 1'b1;
      valid_q      <= 1'b0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      user_q       <= '0;
      keep_q       <= '0;
      data_q       <= '0;
      src0_cnt_q   <= '0;
      src1_cnt_q   <= '0;
      err_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_beat_q <= first_beat_d;
      valid_q      <= valid_d;
      start_q      <= start_d;
      end_q        <= end_d;
      user_q       <= user_d;
      keep_q       <= keep_d;
      data_q       <= data_d;
      src0_cnt_q   <= src0_cnt_d;
      src1_cnt_q   <= src1_cnt_d;
      err_cnt_q    <= err_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO pops must land in the same cycle as the head word is consumed.
  assign o_src0_rd_en    = pop_c && !grant_q;
  assign o_src1_rd_en    = pop_c && grant_q;

  assign o_tx_pkt_valid  = valid_q;
  assign o_tx_pkt_start  = start_q;
  assign o_tx_pkt_end    = end_q;
  assign ov_tx_pkt_user  = user_q;
  assign ov_tx_pkt_keep  = keep_q;
  assign ov_tx_pkt_data  = data_q;
  assign o_busy          = busy_q;
  assign ov_src0_pkt_cnt = src0_cnt_q;
  assign ov_src1_pkt_cnt = src1_cnt_q;
  assign ov_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_egress_pkt_arbiter.sv
// Bench for egress_pkt_arbiter: queue-backed FIFO models feed the DUT and a packet-level
// round-robin model predicts the delivered beat stream and counters.
module tb_egress_pkt_arbiter;

  localparam int unsigned QW = 288;
  typedef logic [281:0] beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, e0, e1, rd0, rd1, tv, ts, te, ready, busy;
  logic [QW-1:0] d0, d1;
  logic [15:0]   user, err;
  logic [7:0]    keep;
  logic [255:0]  data;
  logic [31:0]   c0, c1;

  egress_pkt_arbiter dut (
    .clk(clk), .rst(rst), .i_enable(en),
    .i_src0_empty(e0), .o_src0_rd_en(rd0), .iv_src0_data(d0),
    .i_src1_empty(e1), .o_src1_rd_en(rd1), .iv_src1_data(d1),
    .o_tx_pkt_valid(tv), .o_tx_pkt_start(ts), .o_tx_pkt_end(te),
    .ov_tx_pkt_user(user), .ov_tx_pkt_keep(keep), .ov_tx_pkt_data(data),
    .i_tx_pkt_ready(ready), .o_busy(busy),
    .ov_src0_pkt_cnt(c0), .ov_src1_pkt_cnt(c1), .ov_err_cnt(err)
  );

  // FIFO contents and the packet-level view of what each source holds.
  logic [QW-1:0] fq[2][$];
  int            gq[2][$];
  int            lq[2][$];
  beat_t         pkq[2][$];
  beat_t         got[$];
  beat_t         exp_q[$];
  logic          vlog[$];
  logic          rlog[$];

  int          checks = 0;
  int          errors = 0;
  int          rmode  = 0;
  int          cyc    = 0;
  bit          prev_stall = 1'b0;
  beat_t       prev_beat;
  int          m_lg;
  logic [31:0] m_cnt[2];
  logic [15:0] m_err;

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [QW-1:0] rand_word();
    logic [QW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic add_unit(input int s, input int garb, input int len, input bit mid_rand);
    logic [QW-1:0] w;
    for (int i = 0; i < garb; i++) begin
      w = rand_word();
      w[280] = 1'b0;
      fq[s].push_back(w);
    end
    for (int i = 0; i < len; i++) begin
      w = rand_word();
      if (i == 0) w[280] = 1'b1;
      else if (!mid_rand) w[280] = 1'b0;
      w[281] = (i == len - 1);
      fq[s].push_back(w);
      pkq[s].push_back(w[281:0]);
    end
    gq[s].push_back(garb);
    lq[s].push_back(len);
  endtask

  task automatic drive_fifos();
    e0 = (fq[0].size() == 0);
    e1 = (fq[1].size() == 0);
    d0 = e0 ? '0 : fq[0][0];
    d1 = e1 ? '0 : fq[1][0];
  endtask

  task automatic model_reset();
    m_lg = 1;
    m_cnt[0] = '0;
    m_cnt[1] = '0;
    m_err = '0;
  endtask

  // Whole packets alternate between sources; a lone source keeps the grant.
  task automatic run_model();
    int g, len, gc, e;
    while (lq[0].size() > 0 || lq[1].size() > 0) begin
      if (lq[0].size() > 0 && lq[1].size() > 0) g = 1 - m_lg;
      else g = (lq[0].size() > 0) ? 0 : 1;
      gc  = gq[g].pop_front();
      len = lq[g].pop_front();
      e = int'(m_err) + gc;
      m_err = (e > 65535) ? 16'hFFFF : 16'(e);
      for (int i = 0; i < len; i++) exp_q.push_back(pkq[g].pop_front());
      m_cnt[g] = m_cnt[g] + 32'd1;
      m_lg = g;
    end
  endtask

  // One clock: drive ready, sample just after the negedge, apply pops after posedge.
  task automatic cycle();
    logic  rdy, p0, p1;
    beat_t cur;
    case (rmode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 99) < 70);
      default: rdy = (cyc % 3 == 0);
    endcase
    ready = rdy;
    #1;
    cur = {te, ts, user, keep, data};
    if (prev_stall) chk("stall_hold", 288'({tv, cur}), 288'({1'b1, prev_beat}));
    if (tv && !rdy) chk("no_pop_in_stall", 288'({rd0, rd1}), 288'(0));
    if (rd0 || rd1) chk("pop_nonempty", 288'({rd0 & e0, rd1 & e1}), 288'(0));
    prev_stall = tv && !rdy;
    prev_beat  = cur;
    if (tv && rdy) got.push_back(cur);
    vlog.push_back(tv);
    rlog.push_back(rd0);
    p0 = rd0;
    p1 = rd1;
    @(posedge clk);
    #1;
    if (p0 && fq[0].size() > 0) void'(fq[0].pop_front());
    if (p1 && fq[1].size() > 0) void'(fq[1].pop_front());
    drive_fifos();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    prev_stall = 1'b0;
    got.delete();
    exp_q.delete();
    model_reset();
  endtask

  task automatic drain_and_check(input string tag);
    int n = 0;
    run_model();
    while (!(got.size() >= exp_q.size() && fq[0].size() == 0 && fq[1].size() == 0 && !busy)
           && n < 3000) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 288'(n < 3000), 288'(1));
    chk({tag, "_nbeats"}, 288'(got.size()), 288'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_beat"}, 288'(got[i]), 288'(exp_q[i]));
    chk({tag, "_cnt0"}, 288'(c0), 288'(m_cnt[0]));
    chk({tag, "_cnt1"}, 288'(c1), 288'(m_cnt[1]));
    chk({tag, "_err"}, 288'(err), 288'(m_err));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] vv, rv;
    int         n, resid;
    rst = 1'b1; en = 1'b0; ready = 1'b0;
    drive_fifos();
    model_reset();
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_txvalid", 288'({tv, ts, te}), 288'(0));
    chk("rst_fields", 288'({user, keep, data}), 288'(0));
    chk("rst_rden", 288'({rd0, rd1}), 288'(0));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_cnts", 288'({c0, c1, err}), 288'(0));

    // Single 3-beat packet: two-cycle latency from empty falling to valid.
    en = 1'b1; rmode = 0;
    add_unit(0, 0, 3, 1'b1);
    drive_fifos();
    vlog.delete(); rlog.delete();
    repeat (6) cycle();
    for (int i = 0; i < 6; i++) begin
      vv[5-i] = vlog[i];
      rv[5-i] = rlog[i];
    end
    chk("single_valid_timing", 288'(vv), 288'(6'b001110));
    chk("single_rden_timing", 288'(rv), 288'(6'b011100));
    drain_and_check("single");

    // Fairness: four 2-beat packets per source.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_unit(0, 0, 2, 1'b1);
      add_unit(1, 0, 2, 1'b1);
    end
    drive_fifos();
    drain_and_check("fair");

    // Backpressure with ready pattern 1,0,0.
    rmode = 2;
    add_unit(0, 0, 4, 1'b1);
    drive_fifos();
    drain_and_check("bp");

    // Framing error ahead of a single-beat packet.
    do_reset();
    rmode = 0;
    add_unit(1, 1, 1, 1'b1);
    drive_fifos();
    drain_and_check("frame");

    // Randomized traffic with random backpressure.
    rmode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 2; s++) begin
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++)
          add_unit(s, $urandom_range(0, 2), $urandom_range(1, 5), 1'b1);
      end
      drive_fifos();
      drain_and_check("rand");
    end

    // Enable low holds off grants; then reset mid-packet.
    do_reset();
    rmode = 0; en = 1'b0;
    add_unit(0, 0, 5, 1'b0);
    add_unit(1, 0, 2, 1'b1);
    drive_fifos();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("dis_idle", 288'({rd0, rd1, tv}), 288'(0));
    end
    en = 1'b1;
    n = 0;
    while (got.size() < 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("rst_mid_reach", 288'(got.size()), 288'(2));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    prev_stall = 1'b0;
    chk("rst_mid_valid", 288'(tv), 288'(0));
    chk("rst_mid_busy", 288'(busy), 288'(0));
    chk("rst_mid_cnts", 288'({c0, c1, err}), 288'(0));
    got.delete(); exp_q.delete();
    model_reset();
    resid = fq[0].size();
    gq[0].delete(); lq[0].delete(); pkq[0].delete();
    add_unit(0, 0, 2, 1'b1);
    gq[0][0] = resid;
    drive_fifos();
    drain_and_check("rst_resume");

    // Packet counter wrap.
    do_reset();
    force dut.src0_cnt_q = 32'hFFFF_FFFF;
    cycle();
    release dut.src0_cnt_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    add_unit(0, 0, 1, 1'b1);
    drive_fifos();
    drain_and_check("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
